// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - sequential frog-versus-car overlap scanner, one car per clock
module collision_scanner #(
    parameter int NUM_LANES     = 6,
    parameter int CARS_PER_LANE = 3,
    parameter int COORD_W       = 10,
    parameter int BLOCKSIZE     = 32,
    parameter int LANE0_Y       = 256,
    parameter int WRAP          = 1,
    parameter int SCREEN_W      = 640,
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int CAR_W  = (CARS_PER_LANE > 1) ? $clog2(CARS_PER_LANE) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [COORD_W-1:0]                         frog_x,
    input  logic [COORD_W-1:0]                         frog_y,
    input  logic [COORD_W-1:0]                         frog_size,
    input  logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0] car_x,
    input  logic [NUM_LANES*COORD_W-1:0]               lane_length,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       hit,
    output logic [LANE_W-1:0]                          hit_lane,
    output logic [CAR_W-1:0]                           hit_car,
    output logic [NUM_LANES-1:0]                       lane_hit_mask
);

    localparam int N     = NUM_LANES * CARS_PER_LANE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int W2    = COORD_W + 2;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_next;

    logic [COORD_W-1:0]   fx, fy, fs;
    logic [IDX_W-1:0]     idx;
    logic [LANE_W-1:0]    lane_idx;
    logic [CAR_W-1:0]     car_idx;
    logic [W2-1:0]        lane_y;

    logic                 acc_hit;
    logic [NUM_LANES-1:0] acc_mask;
    logic [LANE_W-1:0]    acc_lane;
    logic [CAR_W-1:0]     acc_car;

    logic                 hit_nxt;
    logic [NUM_LANES-1:0] mask_nxt;
    logic [LANE_W-1:0]    lane_nxt;
    logic [CAR_W-1:0]     car_nxt;

    logic [W2-1:0] fx2, fy2, fs2, car_pos, car_len, car_end;
    logic          ytouch, xtouch, wrap_touch, overlap, last;

    // Lane and car counters run alongside the flat index so no divider is needed.
    assign last    = (idx == IDX_W'(N - 1));
    assign fx2     = W2'(fx);
    assign fy2     = W2'(fy);
    assign fs2     = W2'(fs);
    assign car_pos = W2'(car_x[idx*COORD_W +: COORD_W]);
    assign car_len = W2'(lane_length[lane_idx*COORD_W +: COORD_W]);
    assign car_end = car_pos + car_len;

    assign ytouch     = (fy2 < lane_y + W2'(BLOCKSIZE)) && (fy2 + fs2 > lane_y);
    assign xtouch     = (fx2 < car_end) && (fx2 + fs2 > car_pos);
    assign wrap_touch = (WRAP != 0) && (car_end > W2'(SCREEN_W))
                        && (fx2 < car_end - W2'(SCREEN_W));
    assign overlap    = (state == SCAN) && ytouch && (xtouch || wrap_touch);

    assign busy = (state == SCAN);
    assign done = (state == DONE);

    always_comb begin
        hit_nxt  = acc_hit;
        mask_nxt = acc_mask;
        lane_nxt = acc_lane;
        car_nxt  = acc_car;
        if (overlap) begin
            hit_nxt            = 1'b1;
            mask_nxt[lane_idx] = 1'b1;
            if (!acc_hit) begin
                lane_nxt = lane_idx;
                car_nxt  = car_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            fx            <= '0;
            fy            <= '0;
            fs            <= '0;
            idx           <= '0;
            lane_idx      <= '0;
            car_idx       <= '0;
            lane_y        <= '0;
            acc_hit       <= 1'b0;
            acc_mask      <= '0;
            acc_lane      <= '0;
            acc_car       <= '0;
            hit           <= 1'b0;
            hit_lane      <= '0;
            hit_car       <= '0;
            lane_hit_mask <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        fx       <= frog_x;
                        fy       <= frog_y;
                        fs       <= frog_size;
                        idx      <= '0;
                        lane_idx <= '0;
                        car_idx  <= '0;
                        lane_y   <= W2'(LANE0_Y);
                        acc_hit  <= 1'b0;
                        acc_mask <= '0;
                        acc_lane <= '0;
                        acc_car  <= '0;
                    end
                end
                SCAN: begin
                    acc_hit  <= hit_nxt;
                    acc_mask <= mask_nxt;
                    acc_lane <= lane_nxt;
                    acc_car  <= car_nxt;
                    idx      <= idx + 1'b1;
                    if (car_idx == CAR_W'(CARS_PER_LANE - 1)) begin
                        car_idx  <= '0;
                        lane_idx <= lane_idx + 1'b1;
                        lane_y   <= lane_y + W2'(BLOCKSIZE);
                    end else begin
                        car_idx <= car_idx + 1'b1;
                    end
                    // Results include the final car, so load from the next-accumulator values.
                    if (last) begin
                        hit           <= hit_nxt;
                        lane_hit_mask <= mask_nxt;
                        hit_lane      <= lane_nxt;
                        hit_car       <= car_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Parametrised, time-multiplexed frog-versus-car collision detector for the frogger datapath. It replaces the flat combinational overlap check over fixed lanes and cars with a sequential scan over NUM_LANES × CARS_PER_LANE cars, one car per clock. It adds optional horizontal wrap-around of cars, a per-lane hit mask, and identification of the first car hit. It sits between the car/frog position generators and the game-state logic, and runs one scan per `start` pulse (typically once per frame).

## Interface
- NUM_LANES, 6, number of car lanes
- CARS_PER_LANE, 3, cars per lane
- COORD_W, 10, coordinate width in bits
- BLOCKSIZE, 32, lane height in pixels
- LANE0_Y, 256, top row of lane 0; lane i top is LANE0_Y + i*BLOCKSIZE
- WRAP, 1, 1 = cars extending past SCREEN_W also occupy columns from 0
- SCREEN_W, 640, visible width in pixels
- clk  in  1  system clock (25.1 MHz pixel clock)
- reset  in  1  synchronous, active-high reset
- start  in  1  scan request pulse; accepted only in IDLE
- frog_x, frog_y  in  COORD_W each  frog top-left corner
- frog_size  in  COORD_W  frog edge length
- car_x  in  NUM_LANES*CARS_PER_LANE*COORD_W  flattened; car c of lane l occupies slice index l*CARS_PER_LANE+c
- lane_length  in  NUM_LANES*COORD_W  flattened car length per lane
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- hit  out  1  at least one overlap in last scan
- hit_lane  out  $clog2(NUM_LANES) (min 1)  lane of first hit
- hit_car  out  $clog2(CARS_PER_LANE) (min 1)  car of first hit
- lane_hit_mask  out  NUM_LANES  bit l set if any car in lane l overlapped

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN when `start`=1.
  - SCAN → DONE after index NUM_LANES*CARS_PER_LANE-1 is evaluated.
  - DONE → IDLE unconditionally.
- On acceptance of `start`:
  - frog_x, frog_y and frog_size are snapshotted into registers.
  - Scan index cleared to 0; internal accumulators (hit, mask, first-hit index) cleared.
- `car_x` and `lane_length` are sampled live, one slice per SCAN cycle. Callers hold them stable for the scan.
- Per-car evaluation (index n → lane l = n / CARS_PER_LANE, car c = n % CARS_PER_LANE):
  - All sums computed at COORD_W+2 bits, so there is no overflow.
  - ytouch = fy < lane_y+BLOCKSIZE AND fy+fs > lane_y.
  - end = car_x + len.
  - xtouch = fx < end AND fx+fs > car_x.
  - If WRAP=1 and end > SCREEN_W, additionally xtouch |= fx < end−SCREEN_W.
  - Overlap = xtouch AND ytouch. All comparisons are strict (half-open intervals), so merely abutting edges is not a hit.
- On overlap:
  - Set accumulated hit and lane mask bit l.
  - Record (l, c) only if no earlier hit in this scan. First hit = lowest scan index.
- Results update:
  - hit, hit_lane, hit_car and lane_hit_mask load from the accumulators on entry to DONE.
  - They hold until the next DONE or reset.
  - hit_lane/hit_car are 0 when hit=0.
- `start` while in SCAN or DONE is ignored, with no queuing.
- reset in any state (including mid-scan):
  - Next state IDLE.
  - All outputs and accumulators 0.
  - Partial scan discarded.

## Timing
- Reset values: busy=0, done=0, hit=0, hit_lane=0, hit_car=0, lane_hit_mask=0.
- `start` sampled high at edge k → busy=1 in cycles k+1 … k+N, where N = NUM_LANES*CARS_PER_LANE.
- done=1 and new results visible in cycle k+N+1; busy=0 in that cycle.
- Earliest next accepted start: edge k+N+2 (FSM in IDLE). Default N=18, so latency is 19 cycles from start edge to done.
- done is exactly one cycle wide; never asserted without a preceding accepted start.
- Single-cycle evaluation path: one car's compare per clock. No multi-cycle paths.

## Test plan
- Reset then idle, start never asserted → all outputs 0 indefinitely; busy never rises.
- Frog (320,448,32), all cars at x=0 → start; done at k+19 with hit=0, mask=0, busy high exactly 18 cycles.
- Frog (100,288,32); lane1 car1 x=90, lane length 64; all other cars at x=600 → hit=1, hit_lane=1, hit_car=1, mask=6'b000010.
- Frog (100,288,32); lane1 car0 x=40, car2 x=110 (length 64, both overlap) → hit_car=0, reporting the first hit only.
- WRAP=1: frog (10,256,32); lane0 car0 x=620, length 64 (wraps to end 44) → hit=1, lane 0. Same stimulus with WRAP=0 → hit=0.
- Edge/abort cases:
  - Frog x=154, car x=90, length 64 (abutting) → no hit.
  - start pulsed again at k+5 → ignored; done still at k+19.
  - reset at k+10 → busy=0 next cycle, no done, outputs 0.
